// File: rtl/gf_pkg.sv
// GF(2^m) helpers for the Chien column: constant-multiplier matrix builders,
// symbol type and the column sequencer state encoding.
package gf_pkg;

    localparam int unsigned GF_M     = 13;
    // Upper bound on symbol width handled by the constant functions (m < 32).
    localparam int unsigned GF_MAX_M = 32;

    typedef logic [GF_M-1:0]                     gf_sym_t;
    typedef logic [GF_MAX_M-1:0]                 gf_word_t;
    typedef logic [GF_MAX_M-1:0][GF_MAX_M-1:0]   gf_mat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } gf_state_t;

    // Multiply by alpha (x) modulo the primitive polynomial; x^m is implicit.
    function automatic gf_word_t gf_mulx(input gf_word_t x, input int unsigned m,
                                         input gf_word_t poly);
        gf_word_t mask;
        gf_word_t r;
        mask = (gf_word_t'(1) << m) - gf_word_t'(1);
        r    = (x << 1) & mask;
        if (x[m-1]) begin
            r = r ^ (poly & mask);
        end
        return r;
    endfunction

    // alpha^k by repeated multiplication by alpha.
    function automatic gf_word_t gf_pow(input int unsigned k, input int unsigned m,
                                        input gf_word_t poly);
        gf_word_t r;
        r = gf_word_t'(1);
        for (int unsigned i = 0; i < k; i++) begin
            r = gf_mulx(r, m, poly);
        end
        return r;
    endfunction

    // Row c of the matrix is the image of basis alpha^c, i.e. alpha^(k+c).
    function automatic gf_mat_t gf_mat(input int unsigned k, input int unsigned m,
                                       input gf_word_t poly);
        gf_mat_t  mat;
        gf_word_t col;
        mat = '0;
        col = gf_pow(k, m, poly);
        for (int unsigned c = 0; c < m; c++) begin
            mat[c] = col;
            col    = gf_mulx(col, m, poly);
        end
        return mat;
    endfunction

endpackage

// File: rtl/gf_chien_column_if.sv
// Load/stream bundle for the Chien column: start request in, product beats out.
interface gf_chien_column_if #(
    parameter int unsigned M = 13,
    parameter int unsigned P = 8
);
    localparam int unsigned SW = 16;

    logic            load;
    logic [M-1:0]    b;
    logic [SW-1:0]   num_steps;
    logic            out_ready;
    logic            out_valid;
    logic [P*M-1:0]  prod;
    logic            busy;
    logic            done;
    logic [SW-1:0]   step_idx;

    modport master (
        output load, b, num_steps, out_ready,
        input  out_valid, prod, busy, done, step_idx
    );

    modport slave (
        input  load, b, num_steps, out_ready,
        output out_valid, prod, busy, done, step_idx
    );
endinterface

// File: rtl/gf_const_mult.sv
// Multiply a GF(2^M) symbol by the constant alpha^K as a fixed XOR network.
module gf_const_mult
    import gf_pkg::*;
#(
    parameter int unsigned  M    = 13,
    parameter logic [M-1:0] POLY = M'(13'h001B),
    parameter int unsigned  K    = 1
) (
    input  logic [M-1:0] x,
    output logic [M-1:0] y_c
);
    localparam gf_mat_t MAT = gf_mat(K, M, gf_word_t'(POLY));

    // Each set input bit contributes its constant basis image.
    always_comb begin
        y_c = '0;
        for (int unsigned c = 0; c < M; c++) begin
            if (x[c]) begin
                y_c = y_c ^ MAT[c][M-1:0];
            end
        end
    end
endmodule

// File: rtl/gf_chien_column.sv
// Chien search column: streams P lanes of acc*alpha^(COL*(i+1)) per beat and
// advances acc by alpha^(COL*P) on each accepted beat.
// Optional macro GF_CHIEN_OUTREG_EN adds a registered output stage for
// prod/out_valid/step_idx (one extra cycle of latency, backpressure-safe).
module gf_chien_column
    import gf_pkg::*;
#(
    parameter int unsigned  M    = 13,
    parameter logic [M-1:0] POLY = M'(13'h001B),
    parameter int unsigned  P    = 8,
    parameter int unsigned  COL  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    gf_chien_column_if.slave bus
);
    localparam int unsigned CW = 16;
    localparam int unsigned PW = P * M;

    gf_state_t     state;
    logic [M-1:0]  acc;
    logic [M-1:0]  acc_step_c;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic [PW-1:0] lanes_c;
    logic          core_valid_c;
    logic          core_ready_c;
    logic          core_fire_c;
    logic          fin_c;

    // Lane i scales the accumulator by alpha^(COL*(i+1)).
    for (genvar i = 0; i < P; i++) begin : g_lane
        gf_const_mult #(
            .M    (M),
            .POLY (POLY),
            .K    (COL * (i + 1))
        ) u_lane (
            .x   (acc),
            .y_c (lanes_c[i*M +: M])
        );
    end

    // Accumulator stepper: advance by a whole beat of lanes.
    gf_const_mult #(
        .M    (M),
        .POLY (POLY),
        .K    (COL * P)
    ) u_step (
        .x   (acc),
        .y_c (acc_step_c)
    );

    assign core_valid_c = (state == RUN) && (cnt != '0);
    assign core_fire_c  = core_valid_c && core_ready_c;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == FIN);

`ifdef GF_CHIEN_OUTREG_EN
    logic          ov_q;
    logic [PW-1:0] prod_q;
    logic [CW-1:0] sidx_q;

    // Stage accepts a new beat when empty or when its beat is being taken.
    assign core_ready_c = !ov_q || bus.out_ready;
    // Finish only once every beat is issued and the stage is draining.
    assign fin_c        = (cnt == '0) && core_ready_c;

    assign bus.out_valid = ov_q;
    assign bus.prod      = prod_q;
    assign bus.step_idx  = sidx_q;

    // Output stage: reload on empty/handshake; zeros when nothing is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q   <= 1'b0;
            prod_q <= '0;
            sidx_q <= '0;
        end else if ((state == IDLE) && bus.load) begin
            sidx_q <= '0;
        end else if (core_ready_c) begin
            ov_q   <= core_valid_c;
            prod_q <= core_valid_c ? lanes_c : '0;
            if (core_valid_c) begin
                sidx_q <= idx;
            end
        end
    end
`else
    assign core_ready_c  = bus.out_ready;
    assign fin_c         = core_fire_c && (cnt == CW'(1));

    assign bus.out_valid = core_valid_c;
    assign bus.prod      = core_valid_c ? lanes_c : '0;
    assign bus.step_idx  = idx;
`endif

    // Sequencer: capture on load, step acc per accepted beat, pulse FIN once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        acc   <= bus.b;
                        cnt   <= bus.num_steps;
                        idx   <= '0;
                        state <= (bus.num_steps != '0) ? RUN : FIN;
                    end
                end
                RUN: begin
                    if (core_fire_c) begin
                        acc <= acc_step_c;
                        cnt <= cnt - CW'(1);
                        idx <= idx + CW'(1);
                    end
                    if (fin_c) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
